// File: rtl/bch_berlekamp_massey.sv
// Inversionless Berlekamp-Massey stage of the BCH decoder.
// Takes 2*DELTA syndromes serially and produces the error-locator
// polynomial sigma(x) and its degree L. sigma is then streamed out
// lowest coefficient first. The design is fully sequential: one
// coefficient term per cycle, with a single pair of GF(2^M) multipliers
// shared between the discrepancy and update phases.
module bch_berlekamp_massey #(
    parameter int PARAM_M     = 9,
    parameter int PARAM_POLY  = 'h211,
    parameter int PARAM_DELTA = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   syn_valid,
    output logic                                   syn_ready,
    input  logic [PARAM_M-1:0]                     syn_data,
    output logic                                   busy,
    output logic                                   sig_valid,
    output logic [PARAM_M-1:0]                     sig_data,
    output logic                                   sig_last,
    output logic [$clog2(2*PARAM_DELTA+1)-1:0]     deg,
    output logic                                   fail
);

    localparam int NSYN = 2 * PARAM_DELTA;
    localparam int CW   = $clog2(2 * PARAM_DELTA + 1);
    localparam int JW   = $clog2(PARAM_DELTA + 1);
    localparam int SW   = $clog2(NSYN);

    localparam logic [PARAM_M-1:0] POLY_LO = PARAM_POLY[PARAM_M-1:0];
    localparam logic [PARAM_M-1:0] GF_ONE  = 1;
    localparam logic [JW-1:0]      J_LAST  = JW'(PARAM_DELTA);
    localparam logic [SW-1:0]      K_LAST  = SW'(NSYN - 1);
    localparam logic [CW-1:0]      R_LAST  = CW'(NSYN - 1);
    localparam logic [CW-1:0]      CW_ONE  = 1;
    localparam logic [CW-1:0]      T_LIM   = CW'(PARAM_DELTA);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        DISC = 3'd2,
        UPD  = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [PARAM_M-1:0] sigma_q [0:PARAM_DELTA];
    logic [PARAM_M-1:0] b_q     [0:PARAM_DELTA];
    logic [PARAM_M-1:0] syn_q   [0:NSYN-1];
    logic [PARAM_M-1:0] gamma_q;
    logic [PARAM_M-1:0] delta_q;
    logic [PARAM_M-1:0] bprev_q;
    logic [CW-1:0]      l_q;
    logic [CW-1:0]      r_q;
    logic [SW-1:0]      k_q;
    logic [JW-1:0]      j_q;
    logic [CW-1:0]      deg_q;
    logic               fail_q;

    logic               j_last;
    logic [CW-1:0]      j_ext;
    logic               s_ok;
    logic [SW-1:0]      s_idx;
    logic [PARAM_M-1:0] s_term;
    logic [PARAM_M-1:0] sig_j;
    logic [PARAM_M-1:0] b_j;
    logic [PARAM_M-1:0] bprev_use;
    logic               upd_cond;
    logic [CW-1:0]      l_new;
    logic [CW-1:0]      l_upd;
    logic [PARAM_M-1:0] mul0_a, mul0_b, mul0_p;
    logic [PARAM_M-1:0] mul1_a, mul1_b, mul1_p;

    // GF(2^M) product: Horner evaluation over the bits of b, reducing by
    // the field polynomial after every shift.
    function automatic logic [PARAM_M-1:0] gf_mul(input logic [PARAM_M-1:0] a,
                                                  input logic [PARAM_M-1:0] b);
        logic [PARAM_M-1:0] p;
        p = '0;
        for (int i = PARAM_M - 1; i >= 0; i--) begin
            p = {p[PARAM_M-2:0], 1'b0} ^ (p[PARAM_M-1] ? POLY_LO : '0);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    assign j_last = (j_q == J_LAST);
    assign j_ext  = CW'(j_q);

    // S_(r+1-j) lives at index r-j; terms reaching below S_1 contribute zero.
    assign s_ok   = (j_ext <= r_q);
    assign s_idx  = SW'(r_q - j_ext);
    assign s_term = s_ok ? syn_q[s_idx] : '0;

    assign sig_j  = sigma_q[j_q];
    assign b_j    = b_q[j_q];

    // B is rewritten in place, so the old B_(j-1) is carried forward in
    // bprev_q; B_(-1) is zero at the start of every update pass.
    assign bprev_use = (j_q == '0) ? '0 : bprev_q;

    // L and gamma stay frozen through an update pass, so the branch
    // decision is constant for all j of that pass.
    assign upd_cond = (delta_q != '0) && ({l_q, 1'b0} <= {1'b0, r_q});
    assign l_new    = r_q + CW_ONE - l_q;
    assign l_upd    = upd_cond ? l_new : l_q;

    // Shared multipliers: DISC uses mul0 for sigma_j*S; UPD uses mul0 for
    // gamma*sigma_j and mul1 for delta*B_(j-1).
    assign mul0_a = (state_q == UPD) ? gamma_q : sig_j;
    assign mul0_b = (state_q == UPD) ? sig_j   : s_term;
    assign mul0_p = gf_mul(mul0_a, mul0_b);
    assign mul1_a = delta_q;
    assign mul1_b = bprev_use;
    assign mul1_p = gf_mul(mul1_a, mul1_b);

    assign deg  = deg_q;
    assign fail = fail_q;

    // State register; reset aborts any decode in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and handshake/stream outputs.
    always_comb begin
        state_d   = state_q;
        syn_ready = 1'b0;
        busy      = 1'b0;
        sig_valid = 1'b0;
        sig_last  = 1'b0;
        sig_data  = '0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                syn_ready = 1'b1;
                busy      = 1'b1;
                if (syn_valid && (k_q == K_LAST)) state_d = DISC;
            end
            DISC: begin
                busy = 1'b1;
                if (j_last) state_d = UPD;
            end
            UPD: begin
                busy = 1'b1;
                if (j_last) state_d = (r_q == R_LAST) ? OUT : DISC;
            end
            OUT: begin
                busy      = 1'b1;
                sig_valid = 1'b1;
                sig_data  = sig_j;
                sig_last  = j_last;
                if (j_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: syndrome capture, discrepancy accumulation, in-place
    // polynomial update and the final degree/fail capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= PARAM_DELTA; i++) begin
                sigma_q[i] <= '0;
                b_q[i]     <= '0;
            end
            for (int i = 0; i < NSYN; i++) syn_q[i] <= '0;
            gamma_q <= '0;
            delta_q <= '0;
            bprev_q <= '0;
            l_q     <= '0;
            r_q     <= '0;
            k_q     <= '0;
            j_q     <= '0;
            deg_q   <= '0;
            fail_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i <= PARAM_DELTA; i++) begin
                            sigma_q[i] <= (i == 0) ? GF_ONE : '0;
                            b_q[i]     <= (i == 0) ? GF_ONE : '0;
                        end
                        gamma_q <= GF_ONE;
                        delta_q <= '0;
                        bprev_q <= '0;
                        l_q     <= '0;
                        r_q     <= '0;
                        k_q     <= '0;
                        j_q     <= '0;
                        deg_q   <= '0;
                        fail_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    j_q <= '0;
                    if (syn_valid) begin
                        syn_q[k_q] <= syn_data;
                        k_q        <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
                    end
                end
                DISC: begin
                    delta_q <= (j_q == '0) ? mul0_p : (delta_q ^ mul0_p);
                    j_q     <= j_last ? '0 : j_q + 1'b1;
                end
                UPD: begin
                    sigma_q[j_q] <= mul0_p ^ mul1_p;
                    bprev_q      <= b_j;
                    b_q[j_q]     <= upd_cond ? sig_j : bprev_use;
                    if (j_last) begin
                        j_q <= '0;
                        r_q <= r_q + CW_ONE;
                        if (upd_cond) begin
                            l_q     <= l_new;
                            gamma_q <= delta_q;
                        end
                        if (r_q == R_LAST) begin
                            deg_q  <= l_upd;
                            fail_q <= (l_upd > T_LIM);
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                OUT: begin
                    j_q <= j_last ? '0 : j_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
